// File: rtl/vga_timing_pkg.sv
// Shared VGA mode definitions for the timing generator and its users.
// A mode record bundles the horizontal/vertical geometry, sync polarities
// and the counter width needed to hold the larger of the two totals.
package vga_timing_pkg;

  typedef struct packed {
    int cnt_w;
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
    int h_pol;
    int v_pol;
  } vga_mode_t;

  // 640x480 @ 60 Hz, 800x525 total, negative syncs
  localparam vga_mode_t MODE_640x480 = '{
    cnt_w:    10,
    h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
    h_pol:    0,   v_pol: 0
  };

  // 800x600 @ 60 Hz, 1056x628 total, positive syncs
  localparam vga_mode_t MODE_800x600 = '{
    cnt_w:    11,
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    h_pol:    1,   v_pol: 1
  };

endpackage

// File: rtl/vga_timing_gen_pix_tick_gen.sv
// Pixel-clock-enable divider: div_cnt runs 0..CLK_DIV-1 and the enable is
// high in the cycle where div_cnt sits at CLK_DIV-1.  tick_adv is the
// combinational look-ahead that lets the counters move on the same edge
// that raises pix_tick, keeping everything cycle-aligned.
module pix_tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick_adv,
  output logic pix_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;

  // Next divider value and the matching enable for the coming edge
  always_comb begin
    div_nxt  = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    tick_adv = (div_nxt == DIV_LAST);
  end

  // Divider state and registered enable; reset parks at 0 with no tick
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      pix_tick <= 1'b0;
    end else begin
      div_cnt  <= div_nxt;
      pix_tick <= tick_adv;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA timing generator with integrated pixel-clock enable.
// Counters start at the last position of the frame so the first tick after
// reset lands on (0,0) and raises frame_start.  Every output is registered
// from the next counter values, so sync, valid and strobes line up with
// h_cnt/v_cnt.
// Optional build macro VGA_TIMING_FRAME_CNT_EN adds frame_cnt, hblank and
// vblank outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CNT_W    = MODE_640x480.cnt_w,
  parameter int H_ACTIVE = MODE_640x480.h_active,
  parameter int H_FP     = MODE_640x480.h_fp,
  parameter int H_SYNC   = MODE_640x480.h_sync,
  parameter int H_BP     = MODE_640x480.h_bp,
  parameter int V_ACTIVE = MODE_640x480.v_active,
  parameter int V_FP     = MODE_640x480.v_fp,
  parameter int V_SYNC   = MODE_640x480.v_sync,
  parameter int V_BP     = MODE_640x480.v_bp,
  parameter int H_POL    = MODE_640x480.h_pol,
  parameter int V_POL    = MODE_640x480.v_pol,
  parameter int CLK_DIV  = 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pix_tick,
  output logic             h_sync,
  output logic             v_sync,
  output logic             valid,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic             hblank,
  output logic             vblank
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic H_ACT_LVL = (H_POL != 0);
  localparam logic V_ACT_LVL = (V_POL != 0);

  // Refuse to elaborate a configuration that cannot produce sane timing
  if (CLK_DIV < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      (2 ** CNT_W) < MAX_TOTAL) begin : g_bad_cfg
    $error("vga_timing_gen: illegal parameter set");
  end

  logic             tick_adv;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_wrap;
  logic             v_wrap;
  logic             hs_in;
  logic             vs_in;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .tick_adv (tick_adv),
    .pix_tick (pix_tick)
  );

  // Next counter position and the sync windows it falls into
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_nxt  = h_cnt;
    v_nxt  = v_cnt;
    if (tick_adv) begin
      h_nxt = h_wrap ? '0 : h_cnt + CNT_W'(1);
      if (h_wrap) begin
        v_nxt = v_wrap ? '0 : v_cnt + CNT_W'(1);
      end
    end
    hs_in = (h_nxt >= H_SYNC_BEG) && (h_nxt < H_SYNC_END);
    vs_in = (v_nxt >= V_SYNC_BEG) && (v_nxt < V_SYNC_END);
  end

  // Counters and registered decode; strobes only fire on an advancing edge
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      valid       <= 1'b0;
      h_sync      <= ~H_ACT_LVL;
      v_sync      <= ~V_ACT_LVL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      valid       <= (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
      h_sync      <= hs_in ? H_ACT_LVL : ~H_ACT_LVL;
      v_sync      <= vs_in ? V_ACT_LVL : ~V_ACT_LVL;
      line_start  <= tick_adv && (h_nxt == '0);
      frame_start <= tick_adv && (h_nxt == '0) && (v_nxt == '0);
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic seen_first;

  // Frame counter skips the frame_start that follows reset; blank flags
  // track the counters like valid does
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt  <= '0;
      seen_first <= 1'b0;
      hblank     <= 1'b1;
      vblank     <= 1'b1;
    end else begin
      hblank <= (h_nxt >= H_ACT_END);
      vblank <= (v_nxt >= V_ACT_END);
      if (tick_adv && (h_nxt == '0) && (v_nxt == '0)) begin
        if (seen_first) begin
          frame_cnt <= frame_cnt + 16'd1;
        end
        seen_first <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen.  Three instances share one clock:
//   A: 640-pixel default horizontal timing, short frame, CLK_DIV=1, negative syncs
//   B: tiny mode, CLK_DIV=3, positive syncs
//   C: 800x600 horizontal timing, CNT_W=11, short frame, positive syncs
// A reference model derives the expected position from the number of pixel
// ticks since reset and pushes one expectation per instance per clock into a
// scoreboard queue; the falling edge pops and compares.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int NI = 3;
  localparam int HA [NI] = '{640, 10, 800};
  localparam int HF [NI] = '{16,  2,  40};
  localparam int HS [NI] = '{96,  3,  128};
  localparam int HB [NI] = '{48,  1,  88};
  localparam int VA [NI] = '{4,   4,  3};
  localparam int VF [NI] = '{1,   1,  1};
  localparam int VS [NI] = '{2,   1,  2};
  localparam int VB [NI] = '{1,   2,  2};
  localparam bit HP [NI] = '{1'b0, 1'b1, 1'b1};
  localparam bit VP [NI] = '{1'b0, 1'b1, 1'b1};
  localparam int DV [NI] = '{1,   3,  1};

  logic clk;
  logic [NI-1:0] rst;

  int checks;
  int failures;
  int cyc;
  int kc [NI];
  int nt [NI];
  bit rst_smp [NI];
  logic [63:0] sb_q [$];
  logic [63:0] obs [NI];

  // DUT A
  logic a_tick, a_hs, a_vs, a_valid, a_ls, a_fs;
  logic [9:0] a_h, a_v;
  logic [15:0] a_fc;
  logic a_hb, a_vb;
  // DUT B
  logic b_tick, b_hs, b_vs, b_valid, b_ls, b_fs;
  logic [4:0] b_h, b_v;
  logic [15:0] b_fc;
  logic b_hb, b_vb;
  // DUT C
  logic c_tick, c_hs, c_vs, c_valid, c_ls, c_fs;
  logic [10:0] c_h, c_v;
  logic [15:0] c_fc;
  logic c_hb, c_vb;

  vga_timing_gen #(
    .CNT_W(10), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(0), .V_POL(0), .CLK_DIV(1)
  ) dut_a (
    .clk(clk), .reset(rst[0]), .pix_tick(a_tick), .h_sync(a_hs), .v_sync(a_vs),
    .valid(a_valid), .h_cnt(a_h), .v_cnt(a_v), .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(a_fc), .hblank(a_hb), .vblank(a_vb)
`endif
  );

  vga_timing_gen #(
    .CNT_W(5), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .H_POL(1), .V_POL(1), .CLK_DIV(3)
  ) dut_b (
    .clk(clk), .reset(rst[1]), .pix_tick(b_tick), .h_sync(b_hs), .v_sync(b_vs),
    .valid(b_valid), .h_cnt(b_h), .v_cnt(b_v), .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(b_fc), .hblank(b_hb), .vblank(b_vb)
`endif
  );

  vga_timing_gen #(
    .CNT_W(MODE_800x600.cnt_w), .H_ACTIVE(MODE_800x600.h_active),
    .H_FP(MODE_800x600.h_fp), .H_SYNC(MODE_800x600.h_sync), .H_BP(MODE_800x600.h_bp),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(MODE_800x600.h_pol), .V_POL(MODE_800x600.v_pol), .CLK_DIV(1)
  ) dut_c (
    .clk(clk), .reset(rst[2]), .pix_tick(c_tick), .h_sync(c_hs), .v_sync(c_vs),
    .valid(c_valid), .h_cnt(c_h), .v_cnt(c_v), .line_start(c_ls), .frame_start(c_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(c_fc), .hblank(c_hb), .vblank(c_vb)
`endif
  );

`ifndef VGA_TIMING_FRAME_CNT_EN
  assign a_fc = '0; assign a_hb = 1'b0; assign a_vb = 1'b0;
  assign b_fc = '0; assign b_hb = 1'b0; assign b_vb = 1'b0;
  assign c_fc = '0; assign c_hb = 1'b0; assign c_vb = 1'b0;
`endif

  assign obs[0] = {8'd0, a_fc, a_hb, a_vb, a_tick, 16'(a_h), 16'(a_v), a_valid, a_hs, a_vs, a_ls, a_fs};
  assign obs[1] = {8'd0, b_fc, b_hb, b_vb, b_tick, 16'(b_h), 16'(b_v), b_valid, b_hs, b_vs, b_ls, b_fs};
  assign obs[2] = {8'd0, c_fc, c_hb, c_vb, c_tick, 16'(c_h), 16'(c_v), c_valid, c_hs, c_vs, c_ls, c_fs};

  // 100 MHz-style system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at cycle %0d", tag, observed, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [NI-1:0] r, input int cycles);
    rst = r;
    repeat (cycles) @(negedge clk);
  endtask

  // Expected output vector from ticks-since-reset n and this clock's tick t
  function automatic logic [63:0] model(input int i, input logic t, input int n);
    int total, p, h, v, fc;
    logic vld, hs, vs, ls, fs, hb, vb;
    total = (HA[i] + HF[i] + HS[i] + HB[i]) * (VA[i] + VF[i] + VS[i] + VB[i]);
    if (n == 0) begin
      h = HA[i] + HF[i] + HS[i] + HB[i] - 1;
      v = VA[i] + VF[i] + VS[i] + VB[i] - 1;
      vld = 1'b0; hs = !HP[i]; vs = !VP[i]; ls = 1'b0; fs = 1'b0;
      fc = 0; hb = 1'b1; vb = 1'b1;
    end else begin
      p   = (n - 1) % total;
      h   = p % (HA[i] + HF[i] + HS[i] + HB[i]);
      v   = p / (HA[i] + HF[i] + HS[i] + HB[i]);
      vld = (h < HA[i]) && (v < VA[i]);
      hs  = (h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HS[i]) ? HP[i] : !HP[i];
      vs  = (v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VS[i]) ? VP[i] : !VP[i];
      ls  = t && (h == 0);
      fs  = t && (p == 0);
      fc  = (n - 1) / total;
      hb  = (h >= HA[i]);
      vb  = (v >= VA[i]);
    end
`ifndef VGA_TIMING_FRAME_CNT_EN
    fc = 0; hb = 1'b0; vb = 1'b0;
`endif
    return {8'd0, 16'(fc), hb, vb, t, 16'(h), 16'(v), vld, hs, vs, ls, fs};
  endfunction

  // Reference model: advance divider/tick counts per instance, queue expectations
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < NI; i++) begin
      logic t;
      t = 1'b0;
      rst_smp[i] = rst[i];
      if (rst[i]) begin
        kc[i] = 0;
        nt[i] = 0;
      end else begin
        kc[i]++;
        t = (((kc[i] + 1) % DV[i]) == 0);
        if (t) nt[i]++;
      end
      sb_q.push_back(model(i, t, nt[i]));
    end
  end

  // Scoreboard: pop one expectation per instance and compare full output vector
  always @(negedge clk) begin
    if (sb_q.size() >= NI) begin
      for (int i = 0; i < NI; i++) begin
        logic [63:0] e;
        e = sb_q.pop_front();
        checkOutput($sformatf("sb_inst%0d", i), obs[i], e);
      end
    end
  end

  // Interval monitors for sync widths, frame period, tick spacing and wrap
  int a_hs_run, a_hs_last, a_vs_run, a_fs_prev, b_tick_prev, c_hs_run, c_hs_last, c_h_prev;
  initial begin
    a_hs_run = 0; a_vs_run = 0; a_fs_prev = -1; b_tick_prev = -1;
    c_hs_run = 0; c_h_prev = 0; a_hs_last = 0; c_hs_last = 0;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (a_hs == 1'b0) begin
        if (a_hs_run == 0) checkOutput("a_hsync_first_h", 64'(a_h), 64'd656);
        a_hs_run++;
        a_hs_last = int'(a_h);
      end else if (a_hs_run != 0) begin
        checkOutput("a_hsync_width", 64'(a_hs_run), 64'd96);
        checkOutput("a_hsync_last_h", 64'(a_hs_last), 64'd751);
        a_hs_run = 0;
      end
      if (a_vs == 1'b0) begin
        a_vs_run++;
      end else if (a_vs_run != 0) begin
        checkOutput("a_vsync_ticks", 64'(a_vs_run), 64'd1600);
        a_vs_run = 0;
      end
      if (a_fs) begin
        if (a_fs_prev >= 0) checkOutput("a_frame_period", 64'(cyc - a_fs_prev), 64'd6400);
        a_fs_prev = cyc;
      end
      if (rst_smp[0]) a_fs_prev = -1;

      if (b_tick) begin
        if (b_tick_prev >= 0) checkOutput("b_tick_period", 64'(cyc - b_tick_prev), 64'd3);
        b_tick_prev = cyc;
      end
      if (rst_smp[1]) b_tick_prev = -1;

      if (c_hs == 1'b1) begin
        if (c_hs_run == 0) checkOutput("c_hsync_first_h", 64'(c_h), 64'd840);
        c_hs_run++;
        c_hs_last = int'(c_h);
      end else if (c_hs_run != 0) begin
        checkOutput("c_hsync_width", 64'(c_hs_run), 64'd128);
        checkOutput("c_hsync_last_h", 64'(c_hs_last), 64'd967);
        c_hs_run = 0;
      end
      if (c_h == 11'd0 && c_h_prev != 0) checkOutput("c_h_wrap_from", 64'(c_h_prev), 64'd1055);
      c_h_prev = int'(c_h);
    end
  end

  // Main sequence: reset, mid-frame reset on A, tick-coincident reset on B
  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    $display("[TB] starting vga_timing_gen bench");
    applyStimulus(3'b111, 3);
    applyStimulus(3'b000, 1);

    for (int w = 0; w < 3000 && kc[0] != 1901; w++) @(negedge clk);
    checkOutput("a_reach_reset_point", 64'(kc[0] == 1901), 64'd1);
    checkOutput("a_pos_pre_reset", {44'd0, a_h, a_v}, {44'd0, 10'd300, 10'd2});
    applyStimulus(3'b001, 1);
    applyStimulus(3'b000, 200);

    for (int w = 0; w < 10 && ((kc[1] + 2) % 3) != 0; w++) @(negedge clk);
    checkOutput("b_reach_tick_point", 64'(((kc[1] + 2) % 3) == 0), 64'd1);
    applyStimulus(3'b010, 1);
    applyStimulus(3'b000, 15000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
